// File: rtl/parity_frame_rx.sv
// Serial start/data/parity/stop frame receiver with parity and framing checks
// and a saturating error counter.
module parity_frame_rx #(
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned ODD_PARITY = 0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_bit,
  input  logic              rx_en,
  input  logic              clr_count,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic [CNT_W-1:0]  err_count,
  output logic              busy
);

  localparam int unsigned BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);
  localparam logic ODD = (ODD_PARITY != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [BC_W-1:0]   r_bit_cnt;
  logic              r_par;

  logic w_exp_par;
  logic w_perr;
  logic w_ferr;
  logic w_done;

  // Error flags for the frame whose stop bit is being sampled this edge.
  assign w_exp_par = (^r_shift) ^ ODD;
  assign w_perr    = (r_par != w_exp_par);
  assign w_ferr    = ~rx_bit;
  assign w_done    = rx_en && (r_state == ST_STOP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_par      <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (rx_en) begin
        case (r_state)
          ST_IDLE: begin
            if (!rx_bit) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= '0;
              busy      <= 1'b1;
            end
          end
          ST_DATA: begin
            r_shift[r_bit_cnt] <= rx_bit;
            if (r_bit_cnt == LAST_BIT) begin
              r_state <= ST_PARITY;
            end else begin
              r_bit_cnt <= r_bit_cnt + BC_W'(1);
            end
          end
          ST_PARITY: begin
            r_par   <= rx_bit;
            r_state <= ST_STOP;
          end
          ST_STOP: begin
            data_out   <= r_shift;
            data_valid <= 1'b1;
            parity_err <= w_perr;
            frame_err  <= w_ferr;
            r_state    <= ST_IDLE;
            busy       <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

  // Saturating count of bad frames; a clear beats a same-edge increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
    end else if (clr_count) begin
      err_count <= '0;
    end else if (w_done && (w_perr || w_ferr) && (err_count != '1)) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

endmodule
